// File: rtl/sync_count_pkg.sv
// Shared types for sync/timing blocks: lock FSM states and
// sync edge-direction constants.
package sync_count_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

endpackage

// File: rtl/sync_to_count_lock_if.sv
// Sync-in / position-out bundle of sync_to_count_lock.
// master: sync source + pixel consumer; slave: the counter block.
interface sync_to_count_lock_if #(
  parameter int COUNT_WIDTH = 10
);
  logic                   i_HSync;
  logic                   i_VSync;
  logic                   o_HSync;
  logic                   o_VSync;
  logic [COUNT_WIDTH-1:0] o_Col_Count;
  logic [COUNT_WIDTH-1:0] o_Row_Count;
  logic                   o_Active;
  logic                   o_Frame_Start;
  logic                   o_Line_Start;
  logic                   o_Locked;
  logic                   o_Sync_Err;

  modport master (
    output i_HSync, i_VSync,
    input  o_HSync, o_VSync, o_Col_Count, o_Row_Count,
    input  o_Active, o_Frame_Start, o_Line_Start,
    input  o_Locked, o_Sync_Err
  );

  modport slave (
    input  i_HSync, i_VSync,
    output o_HSync, o_VSync, o_Col_Count, o_Row_Count,
    output o_Active, o_Frame_Start, o_Line_Start,
    output o_Locked, o_Sync_Err
  );
endinterface

// File: rtl/sync_to_count_lock_edge_detect.sv
// Registers one sync input and flags its leading edge.
// Ports: i_Clk, i_Reset, i_Sync in; o_Sync (1-cycle delayed), o_Edge out.
module sync_edge_detect
  import sync_count_pkg::*;
#(
  parameter bit SYNC_EDGE_RISE = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Sync,
  output logic o_Sync,
  output logic o_Edge
);

  localparam logic LEAD = SYNC_EDGE_RISE ? EDGE_RISE : EDGE_FALL;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) o_Sync <= 1'b0;
    else         o_Sync <= i_Sync;
  end

  // Edge is combinational so counters reset on the same clock
  // that registers the new sync level.
  assign o_Edge = (i_Sync != o_Sync) && (i_Sync == LEAD);

endmodule

// File: rtl/sync_to_count_lock.sv
// Row/column counters aligned to registered syncs, with lock FSM.
// Ports: i_Clk, i_Reset (sync, active-high); bus (slave): syncs in,
// delayed syncs, counts, active, start strobes, lock, error out.
module sync_to_count_lock
  import sync_count_pkg::*;
#(
  parameter int COUNT_WIDTH    = 10,
  parameter int TOTAL_COLS     = 800,
  parameter int TOTAL_ROWS     = 525,
  parameter int ACTIVE_COLS    = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter bit SYNC_EDGE_RISE = 1'b1,
  parameter int LOCK_FRAMES    = 2
) (
  input logic               i_Clk,
  input logic               i_Reset,
  sync_to_count_lock_if.slave bus
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [COUNT_WIDTH-1:0] COL_LAST =
    COUNT_WIDTH'(TOTAL_COLS - 1);
  localparam logic [COUNT_WIDTH-1:0] ROW_LAST =
    COUNT_WIDTH'(TOTAL_ROWS - 1);
  localparam logic [COUNT_WIDTH-1:0] ACT_C =
    COUNT_WIDTH'(ACTIVE_COLS);
  localparam logic [COUNT_WIDTH-1:0] ACT_R =
    COUNT_WIDTH'(ACTIVE_ROWS);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_FRAMES);

  logic h_edge, v_edge;
  logic h_exp, v_exp, viol, err_d;
  logic [COUNT_WIDTH-1:0] col_q, row_q, col_d, row_d, row_inc;
  logic fs_d, ls_d;
  logic act_q, fs_q, ls_q, err_q;
  lock_state_t state_q, state_d;
  logic [GW-1:0] good_q, good_d;

  sync_edge_detect #(.SYNC_EDGE_RISE(SYNC_EDGE_RISE)) u_h (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Sync  (bus.i_HSync),
    .o_Sync  (bus.o_HSync),
    .o_Edge  (h_edge)
  );

  sync_edge_detect #(.SYNC_EDGE_RISE(SYNC_EDGE_RISE)) u_v (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Sync  (bus.i_VSync),
    .o_Sync  (bus.o_VSync),
    .o_Edge  (v_edge)
  );

  assign h_exp = (col_q == COL_LAST);
  assign v_exp = h_exp && (row_q == ROW_LAST);

  // Unexpected edges, plus wraps with no edge (missing sync).
  assign viol = (h_edge && !h_exp) || (v_edge && !v_exp) ||
                (h_exp && !h_edge) || (v_exp && !v_edge);
  assign err_d = (state_q != UNLOCKED) && viol;

  always_comb begin
    row_inc = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    col_d   = col_q + 1'b1;
    row_d   = row_q;
    fs_d    = 1'b0;
    ls_d    = 1'b0;
    if (v_edge) begin
      col_d = '0;
      row_d = '0;
      fs_d  = 1'b1;
      ls_d  = 1'b1;
    end else if (h_edge) begin
      col_d = '0;
      row_d = row_inc;
      ls_d  = 1'b1;
    end else if (h_exp) begin
      col_d = '0;
      row_d = row_inc;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      UNLOCKED: begin
        if (v_edge) begin
          state_d = CHECK;
          good_d  = '0;
        end
      end
      CHECK: begin
        if (err_d) begin
          state_d = UNLOCKED;
          good_d  = '0;
        end else if (v_edge) begin
          good_d = good_q + 1'b1;
          if (good_d == GOOD_MAX) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (err_d) begin
          state_d = UNLOCKED;
          good_d  = '0;
        end
      end
      default: begin
        state_d = UNLOCKED;
        good_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= UNLOCKED;
      good_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      act_q   <= 1'b0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      col_q   <= col_d;
      row_q   <= row_d;
      act_q   <= (col_d < ACT_C) && (row_d < ACT_R);
      fs_q    <= fs_d;
      ls_q    <= ls_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_Col_Count   = col_q;
  assign bus.o_Row_Count   = row_q;
  assign bus.o_Active      = act_q;
  assign bus.o_Frame_Start = fs_q;
  assign bus.o_Line_Start  = ls_q;
  assign bus.o_Sync_Err    = err_q;
  assign bus.o_Locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_sync_to_count_lock.sv
// Directed bench: small 10x6 frame, rising-edge and falling-edge DUTs.
// Table of single-cycle vectors, then multi-frame lock sequences.
module tb_sync_to_count_lock;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_to_count_lock_if #(.COUNT_WIDTH(4)) bus_r ();
  sync_to_count_lock_if #(.COUNT_WIDTH(4)) bus_f ();

  sync_to_count_lock #(
    .COUNT_WIDTH(4), .TOTAL_COLS(10), .TOTAL_ROWS(6),
    .ACTIVE_COLS(6), .ACTIVE_ROWS(4),
    .SYNC_EDGE_RISE(1'b1), .LOCK_FRAMES(2)
  ) dut_r (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus_r)
  );

  sync_to_count_lock #(
    .COUNT_WIDTH(4), .TOTAL_COLS(10), .TOTAL_ROWS(6),
    .ACTIVE_COLS(6), .ACTIVE_ROWS(4),
    .SYNC_EDGE_RISE(1'b0), .LOCK_FRAMES(2)
  ) dut_f (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus_f)
  );

  typedef struct {
    logic [2:0] in;
    int         col;
    int         row;
    logic [6:0] flg;
  } vec_t;

  vec_t tbl [23];
  int nvec = 0;
  int nerr = 0;
  int gc = 0, gr = 0, pc = 0, pr = 0;
  int short_row = -1, skip_row = -1;
  logic grst = 1'b0;
  int act_r = 0, act_f = 0;

  task automatic chk(input string name, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic h, input logic v);
    rst           = r;
    bus_r.i_HSync = h;
    bus_r.i_VSync = v;
    bus_f.i_HSync = ~h;
    bus_f.i_VSync = ~v;
    @(posedge clk);
    #1;
  endtask

  task automatic gen_cycle();
    logic h, v;
    int len;
    h = (gc < 2) && (gr != skip_row);
    v = (gr == 0);
    drive(grst, h, v);
    pc  = gc;
    pr  = gr;
    len = (gr == short_row) ? 9 : 10;
    gc++;
    if (gc == len) begin
      gc = 0;
      gr = (gr + 1) % 6;
    end
  endtask

  function automatic int mis(logic [3:0] c, logic [3:0] r,
                             logic fs, logic ls);
    return int'(c != 4'(pc) || r != 4'(pr) ||
                fs != (pc == 0 && pr == 0) || ls != (pc == 0));
  endfunction

  task automatic run(input int n, input string name,
                     input bit pos_r, input bit pos_f);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      gen_cycle();
      if (pos_r)
        bad += mis(bus_r.o_Col_Count, bus_r.o_Row_Count,
                   bus_r.o_Frame_Start, bus_r.o_Line_Start);
      if (pos_f)
        bad += mis(bus_f.o_Col_Count, bus_f.o_Row_Count,
                   bus_f.o_Frame_Start, bus_f.o_Line_Start);
      bad += int'(bus_r.o_Sync_Err) + int'(bus_f.o_Sync_Err);
      act_r += int'(bus_r.o_Active);
      act_f += int'(bus_f.o_Active);
    end
    chk(name, bad, 0);
  endtask

  task automatic relock(input string name);
    run(120, {name, "_relock"}, 1'b1, 1'b1);
    chk({name, "_lock_lo"}, int'(bus_r.o_Locked), 0);
    gen_cycle();
    chk({name, "_lock_r"}, int'(bus_r.o_Locked), 1);
    chk({name, "_lock_f"}, int'(bus_f.o_Locked), 1);
    chk({name, "_coinc"},
        int'({bus_r.o_Frame_Start, bus_r.o_Line_Start,
              bus_r.o_Sync_Err}), 6);
  endtask

  initial begin
    // in = {rst,h,v}; flg = {act,fs,ls,err,lock,hs,vs}
    tbl[0]  = '{3'b100, 0, 0, 7'b0000000};
    tbl[1]  = '{3'b000, 1, 0, 7'b1000000};
    tbl[2]  = '{3'b000, 2, 0, 7'b1000000};
    tbl[3]  = '{3'b010, 0, 1, 7'b1010010};
    tbl[4]  = '{3'b010, 1, 1, 7'b1000010};
    tbl[5]  = '{3'b000, 2, 1, 7'b1000000};
    tbl[6]  = '{3'b011, 0, 0, 7'b1110011};
    tbl[7]  = '{3'b001, 1, 0, 7'b1000001};
    tbl[8]  = '{3'b011, 0, 1, 7'b1011011};
    tbl[9]  = '{3'b000, 1, 1, 7'b1000000};
    tbl[10] = '{3'b111, 0, 0, 7'b0000000};
    tbl[11] = '{3'b011, 0, 0, 7'b1110011};
    tbl[12] = '{3'b000, 1, 0, 7'b1000000};
    tbl[13] = '{3'b000, 2, 0, 7'b1000000};
    tbl[14] = '{3'b000, 3, 0, 7'b1000000};
    tbl[15] = '{3'b000, 4, 0, 7'b1000000};
    tbl[16] = '{3'b000, 5, 0, 7'b1000000};
    tbl[17] = '{3'b000, 6, 0, 7'b0000000};
    tbl[18] = '{3'b000, 7, 0, 7'b0000000};
    tbl[19] = '{3'b000, 8, 0, 7'b0000000};
    tbl[20] = '{3'b000, 9, 0, 7'b0000000};
    tbl[21] = '{3'b000, 0, 1, 7'b1001000};
    tbl[22] = '{3'b000, 1, 1, 7'b1000000};

    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      chk($sformatf("tbl%0d_col", i),
          int'(bus_r.o_Col_Count), tbl[i].col);
      chk($sformatf("tbl%0d_row", i),
          int'(bus_r.o_Row_Count), tbl[i].row);
      chk($sformatf("tbl%0d_flags", i),
          int'({bus_r.o_Active, bus_r.o_Frame_Start,
                bus_r.o_Line_Start, bus_r.o_Sync_Err,
                bus_r.o_Locked, bus_r.o_HSync, bus_r.o_VSync}),
          int'(tbl[i].flg));
    end

    // Clean frames from reset: rise DUT locks at 3rd VSync edge.
    drive(1'b1, 1'b0, 1'b0);
    gc = 0;
    gr = 0;
    run(60, "A_frame0", 1'b1, 1'b0);
    chk("A_lock_early", int'(bus_r.o_Locked), 0);
    act_f = 0;
    run(60, "A_frame1", 1'b1, 1'b1);
    chk("A_active_f", act_f, 24);
    chk("A_lock_pre", int'(bus_r.o_Locked), 0);
    act_r = 0;
    run(1, "A_edge3", 1'b1, 1'b1);
    chk("A_lock_r", int'(bus_r.o_Locked), 1);
    run(59, "A_frame2", 1'b1, 1'b1);
    chk("A_active_r", act_r, 24);
    chk("A_lock_f_pre", int'(bus_f.o_Locked), 0);
    run(1, "A_edge_f", 1'b1, 1'b1);
    chk("A_lock_f", int'(bus_f.o_Locked), 1);
    run(59, "A_frame3", 1'b1, 1'b1);

    // Short line: early HSync at row 3.
    short_row = 2;
    run(29, "B_pre", 1'b1, 1'b1);
    short_row = -1;
    gen_cycle();
    chk("B_err_r", int'(bus_r.o_Sync_Err), 1);
    chk("B_err_f", int'(bus_f.o_Sync_Err), 1);
    chk("B_unlock", int'({bus_r.o_Locked, bus_f.o_Locked}), 0);
    chk("B_pos", int'({bus_r.o_Row_Count, bus_r.o_Col_Count}), 8'h30);
    chk("B_ls", int'(bus_r.o_Line_Start), 1);
    gen_cycle();
    chk("B_err_once", int'(bus_r.o_Sync_Err), 0);
    run(28, "B_post", 1'b1, 1'b1);
    relock("B");

    // Missing HSync at row 2: counters free-run.
    run(19, "C_pre", 1'b1, 1'b1);
    skip_row = 2;
    gen_cycle();
    chk("C_err", int'(bus_r.o_Sync_Err), 1);
    chk("C_pos", int'({bus_r.o_Row_Count, bus_r.o_Col_Count}), 8'h20);
    chk("C_ls", int'(bus_r.o_Line_Start), 0);
    chk("C_unlock", int'(bus_r.o_Locked), 0);
    gen_cycle();
    chk("C_err_once", int'(bus_r.o_Sync_Err), 0);
    chk("C_col1", int'(bus_r.o_Col_Count), 1);
    skip_row = -1;
    run(38, "C_post", 1'b1, 1'b1);
    relock("C");

    // One-cycle reset mid-frame while locked.
    run(32, "F_pre", 1'b1, 1'b1);
    grst = 1'b1;
    gen_cycle();
    grst = 1'b0;
    chk("F_counts", int'({bus_r.o_Row_Count, bus_r.o_Col_Count}), 0);
    chk("F_flags",
        int'({bus_r.o_Active, bus_r.o_Frame_Start, bus_r.o_Line_Start,
              bus_r.o_Sync_Err, bus_r.o_Locked, bus_r.o_HSync,
              bus_r.o_VSync}), 0);
    chk("F_lock_f", int'(bus_f.o_Locked), 0);
    gen_cycle();
    chk("F_no_err", int'(bus_r.o_Sync_Err), 0);
    run(25, "F_post", 1'b0, 1'b0);
    relock("F");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
